// File: rtl/tfifo_pkg.sv
// tfifo shared sizing helpers and reset constants.
// Optional occupancy port: define TFIFO_OCCUPANCY_EN.
package tfifo_pkg;

  localparam int unsigned RST_PTR = 0;

  function automatic int ptr_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  function automatic int cnt_width(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/tfifo_ptr_ctrl.sv
// tfifo head/tail/count bookkeeping with wrap for any SIZE.
// Optional occupancy port (top level): define TFIFO_OCCUPANCY_EN.
module tfifo_ptr_ctrl
  import tfifo_pkg::*;
#(
  parameter int SIZE = 2,
  localparam int PW = ptr_width(SIZE),
  localparam int CW = cnt_width(SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          do_write,
  input  logic          do_read,
  output logic [PW-1:0] head,
  output logic [PW-1:0] tail,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // SIZE need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(SIZE - 1)) ? PW'(RST_PTR) : p + 1'b1;
  endfunction

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_write) tail_d = nxt(tail_q);
    if (do_read)  head_d = nxt(head_q);
    case ({do_write, do_read})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= PW'(RST_PTR);
      tail_q  <= PW'(RST_PTR);
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = head_q;
  assign tail  = tail_q;
  assign count = count_q;
  assign full  = (count_q == CW'(SIZE));
  assign empty = (count_q == '0);

endmodule

// File: rtl/tfifo.sv
// Transparent elastic FIFO: zero-latency bypass when empty, else queued.
// Optional occupancy port: define TFIFO_OCCUPANCY_EN.
module tfifo
  import tfifo_pkg::*;
#(
  parameter int SIZE     = 2,
  parameter int BITWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BITWIDTH-1:0] ins,
  input  logic                ins_valid,
  input  logic                outs_ready,
  output logic [BITWIDTH-1:0] outs,
  output logic                outs_valid,
  output logic                ins_ready
`ifdef TFIFO_OCCUPANCY_EN
  ,
  output logic [$clog2(SIZE+1)-1:0] occupancy
`endif
);

  localparam int PW = ptr_width(SIZE);
  localparam int CW = cnt_width(SIZE);

  logic [BITWIDTH-1:0] mem_q [SIZE];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;
  logic                full;
  logic                empty;
  logic                bypass;
  logic                do_write;
  logic                do_read;

  tfifo_ptr_ctrl #(.SIZE(SIZE)) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .do_write (do_write),
    .do_read  (do_read),
    .head     (head),
    .tail     (tail),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // ins_ready depends on state only; rst gates both handshake outputs.
  always_comb begin
    ins_ready  = !rst && !full;
    outs_valid = !rst && (!empty || ins_valid);
    outs       = empty ? ins : mem_q[head];
    bypass     = empty && ins_valid && outs_ready;
    do_write   = ins_valid && ins_ready && !bypass;
    do_read    = !rst && !empty && outs_ready;
  end

  always_ff @(posedge clk) begin
    if (do_write) mem_q[tail] <= ins;
  end

`ifdef TFIFO_OCCUPANCY_EN
  assign occupancy = count;
`else
  logic cnt_unused;
  assign cnt_unused = ^count;
`endif

endmodule
